// File: rtl/booth_mult_r4_if.sv
// Start/busy/done handshake and operand/result bus
// for the radix-4 Booth multiplier.
interface booth_mult_r4_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic               tc;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, tc, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, tc, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_mult_r4.sv
// Sequential radix-4 Booth multiplier, two multiplier
// bits retired per clock, signed or unsigned per operation.
module booth_mult_r4 #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  booth_mult_r4_if.slave bus
);
  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N + 1);
  localparam int XW = WIDTH + 2;
  localparam int AW = WIDTH + 4;
  localparam int SW = AW + XW + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, next_state;

  logic          busy_d, done_d;
  logic          busy_q, done_q;
  logic [AW-1:0] a;
  logic [XW-1:0] q;
  logic [XW-1:0] m;
  logic          qm1;
  logic [CW-1:0] cnt;
  logic [AW-1:0] mx;
  logic [AW-1:0] term;
  logic [AW-1:0] sum;
  logic [SW-1:0] nxt;
  logic          last;

  logic [2*WIDTH-1:0] prod;

  function automatic logic [XW-1:0] ext(
    input logic [WIDTH-1:0] x,
    input logic             s
  );
    return {{2{s & x[WIDTH-1]}}, x};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.start) next_state = CALC;
      CALC:    if (last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered,
  // so busy/done have no combinational path from inputs.
  always_comb begin
    busy_d = (next_state != IDLE);
    done_d = (next_state == DONE);
  end

  assign last = (state == CALC) && (cnt == CW'(1));
  assign mx   = {{2{m[XW-1]}}, m};

  always_comb begin
    term = '0;
    unique case ({q[1:0], qm1})
      3'b001, 3'b010: term = mx;
      3'b011:         term = mx << 1;
      3'b100:         term = -(mx << 1);
      3'b101, 3'b110: term = -mx;
      default:        term = '0;
    endcase
  end

  assign sum = a + term;
  assign nxt = $signed({sum, q, qm1}) >>> 2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a      <= '0;
      q      <= '0;
      m      <= '0;
      qm1    <= 1'b0;
      cnt    <= '0;
      prod   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (state == IDLE && bus.start) begin
        a   <= '0;
        q   <= ext(bus.multiplier, bus.tc);
        m   <= ext(bus.multiplicand, bus.tc);
        qm1 <= 1'b0;
        cnt <= CW'(N);
      end else if (state == CALC) begin
        a   <= nxt[SW-1:XW+1];
        q   <= nxt[XW:1];
        qm1 <= nxt[0];
        cnt <= cnt - CW'(1);
        if (last) prod <= nxt[2*WIDTH:1];
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = prod;
endmodule

// File: tb/tb_booth_mult_r4.sv
// Self-checking bench for booth_mult_r4 at WIDTH 16 and 8
// against a plain-arithmetic multiply model.
module tb_booth_mult_r4;
  logic clk;
  logic rst_n;

  booth_mult_r4_if #(.WIDTH(16)) i16 ();
  booth_mult_r4_if #(.WIDTH(8))  i8 ();

  booth_mult_r4 #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i16.slave)
  );

  booth_mult_r4 #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i8.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(
    input bit          t,
    input logic [31:0] x,
    input logic [31:0] y,
    input int          w
  );
    longint sx, sy, p;
    logic [63:0] mask;
    sx = longint'(x);
    sy = longint'(y);
    if (t && x[w-1]) sx = sx - (longint'(1) << w);
    if (t && y[w-1]) sy = sy - (longint'(1) << w);
    p    = sx * sy;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(p) & mask;
  endfunction

  task automatic mul16(
    input  bit          t,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  string       tag,
    output logic [31:0] p
  );
    int lat;
    @(negedge clk);
    i16.tc           = t;
    i16.multiplicand = x;
    i16.multiplier   = y;
    i16.start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i16.start = 1'b0;
    check({tag, "_busy"}, 64'(i16.busy), 64'd1);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (i16.done) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, 64'(lat), 64'd9);
    p = i16.product;
    check({tag, "_prod"}, 64'(p), ref_mul(t, 32'(x), 32'(y), 16));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 64'({i16.done, i16.busy}), 64'd0);
  endtask

  task automatic mul8(
    input bit         t,
    input logic [7:0] x,
    input logic [7:0] y
  );
    int lat;
    @(negedge clk);
    i8.tc           = t;
    i8.multiplicand = x;
    i8.multiplier   = y;
    i8.start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i8.start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (i8.done) begin
        lat = k;
        break;
      end
    end
    check("w8_lat", 64'(lat), 64'd5);
    check("w8_prod", 64'(i8.product), ref_mul(t, 32'(x), 32'(y), 8));
    @(posedge clk);
    #1;
    check("w8_pulse", 64'(i8.done), 64'd0);
  endtask

  initial begin
    logic [31:0] p;
    int ndone;

    rst_n            = 1'b0;
    i16.start        = 1'b0;
    i16.tc           = 1'b0;
    i16.multiplicand = '0;
    i16.multiplier   = '0;
    i8.start         = 1'b0;
    i8.tc            = 1'b0;
    i8.multiplicand  = '0;
    i8.multiplier    = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(i16.busy), 64'd0);
    check("rst_done", 64'(i16.done), 64'd0);
    check("rst_prod", 64'(i16.product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    mul16(1'b0, 16'd7, 16'd3, "u7x3", p);
    check("u7x3_const", 64'(p), 64'h15);
    mul16(1'b1, 16'hFFF9, 16'd3, "sm7x3", p);
    check("sm7x3_const", 64'(p), 64'hFFFFFFEB);
    mul16(1'b1, 16'h8000, 16'h8000, "smin2", p);
    check("smin2_const", 64'(p), 64'h40000000);
    mul16(1'b0, 16'hFFFF, 16'hFFFF, "umax", p);
    check("umax_const", 64'(p), 64'hFFFE0001);
    mul16(1'b1, 16'hFFFF, 16'hFFFF, "sm1", p);
    check("sm1_const", 64'(p), 64'h1);

    // second start in the middle of CALC must be ignored
    @(negedge clk);
    i16.tc           = 1'b0;
    i16.multiplicand = 16'd11;
    i16.multiplier   = 16'd13;
    i16.start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i16.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    i16.multiplicand = 16'd5;
    i16.multiplier   = 16'd5;
    i16.start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i16.start = 1'b0;
    ndone = 0;
    for (int k = 4; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (i16.done) begin
        ndone++;
        check("ign_prod", 64'(i16.product), 64'd143);
      end
    end
    check("ign_ndone", 64'(ndone), 64'd1);
    mul16(1'b0, 16'd5, 16'd5, "after_ign", p);
    check("after_ign_const", 64'(p), 64'd25);

    // asynchronous abort mid-CALC
    @(negedge clk);
    i16.tc           = 1'b0;
    i16.multiplicand = 16'd100;
    i16.multiplier   = 16'd200;
    i16.start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i16.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(i16.busy), 64'd0);
    check("abort_done", 64'(i16.done), 64'd0);
    check("abort_prod", 64'(i16.product), 64'd0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (i16.done) ndone++;
    end
    check("abort_nodone", 64'(ndone), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mul16(1'b0, 16'd2, 16'd3, "post_rst", p);
    check("post_rst_const", 64'(p), 64'd6);

    for (int i = 0; i < 40; i++) begin
      mul16(1'($urandom), 16'($urandom), 16'($urandom), "rnd16", p);
    end
    mul8(1'b1, 8'h80, 8'h80);
    mul8(1'b0, 8'hFF, 8'hFF);
    mul8(1'b1, 8'hFF, 8'h7F);
    for (int i = 0; i < 40; i++) begin
      mul8(1'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
